hls_stream_fifo: RTL and testbench
==================================

Name: hls_stream_fifo

Overview:
- Synchronous single-clock FIFO implementing the arg-side stream protocol consumed by generated read kernels such as fifo_read.
- Sits directly upstream of such kernels:
  - its read_ready / out_data drive the kernel's arg_N_read_ready / arg_N_out_data;
  - the kernel's arg_N_read_valid pops it.
- The write side accepts words from a producer kernel or testbench with the same valid/ready convention.
- The kernel's arg_N_rst drives sclr.

Parameters:
WIDTH, 32, data word width in bits
DEPTH, 16, number of entries; power of two, >= 2
CNT_W, $clog2(DEPTH)+1, width of the occupancy counter (derived, do not override)

Ports:
clk  input  1  clock; all state changes on posedge
rst  input  1  asynchronous active-low reset (0 = reset asserted)
sclr  input  1  synchronous active-high clear (driven by kernel arg_N_rst)
in_data  input  WIDTH  word to push
write_valid  input  1  push request
write_ready  output  1  FIFO can accept a push this cycle
read_valid  input  1  pop request
read_ready  output  1  FIFO holds at least one word
out_data  output  WIDTH  most recently popped word (registered)
count  output  CNT_W  current occupancy, 0..DEPTH

Behaviour:
- Storage and pointers:
  - Storage is a DEPTH x WIDTH register array.
  - wr_ptr and rd_ptr are log2(DEPTH) bits and wrap modulo DEPTH.
  - count is a separate CNT_W-bit register.
- Async reset (rst==0), taking effect immediately, independent of clk:
  - wr_ptr=0, rd_ptr=0, count=0, out_data=0.
  - write_ready=0 and read_ready=0 while rst is low.
  - Array contents are not reset.
- After rst deasserts:
  - write_ready = (count != DEPTH); read_ready = (count != 0).
  - Both are purely functions of registered state; there is no combinational path from write_valid/read_valid.
- push = write_valid & write_ready:
  - On the posedge, mem[wr_ptr] <= in_data and wr_ptr <= wr_ptr+1.
- pop = read_valid & read_ready:
  - On the posedge, out_data <= mem[rd_ptr] and rd_ptr <= rd_ptr+1.
- Read latency and hold:
  - The popped word is visible on out_data from the cycle after the pop edge.
  - out_data holds that value until the next pop.
  - This matches the kernel's sequence: read_ready seen, assert read_valid for 1 cycle, sample out_data next state.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop when 0<count<DEPTH: both occur, count unchanged.
- Full (count==DEPTH):
  - write_ready=0, so write_valid is ignored with no state change.
  - A pop proceeds; write_ready rises the following cycle. There is no same-cycle pass-through.
- Empty (count==0):
  - read_ready=0, so read_valid is ignored; out_data and pointers are unchanged.
  - A push in that cycle proceeds; read_ready rises the next cycle. There is no write-to-read bypass.
- Ignored requests: write_valid while !write_ready and read_valid while !read_ready are dropped silently, with no error flag.
- Ordering: strict FIFO order. Pointer wrap is transparent: entries written at index DEPTH-1 then 0 are read in that order.
- sclr (synchronous, sampled on posedge, rst high):
  - Sets wr_ptr=0, rd_ptr=0, count=0.
  - Has priority over any push/pop in the same cycle, which are discarded.
  - out_data is NOT cleared; it holds its last value.
- Reset mid-operation: an rst assertion at any time discards all contents; the next word read after release is the first word pushed after release.
- in_data and out_data are passed bit-exact; there is no arithmetic on data.

Test Plan:
- Reset then idle:
  - rst low, then high.
  - Required: count=0, read_ready=0, write_ready=1, out_data=0.
  - read_valid=1 for 3 cycles leaves all unchanged.
- Kernel-style single read:
  - push 0xDEADBEEF, then wait for read_ready=1, then read_valid=1 for one cycle.
  - Required: next cycle out_data=0xDEADBEEF, count=0, read_ready=0.
  - out_data still 0xDEADBEEF 5 cycles later.
- Fill to full with DEPTH=16:
  - push 1..16. Required: count=16, write_ready=0.
  - push 99 is ignored.
  - 16 pops return 1..16 in order; after the first pop write_ready=1 the next cycle.
- Wrap and simultaneous:
  - preload 10 words; then 30 cycles of push k and pop together.
  - Required: count stays 10; pop order matches push order across two pointer wraps.
- sclr priority:
  - with count=5, assert sclr together with write_valid=1 and read_valid=1.
  - Required: next cycle count=0, read_ready=0, out_data unchanged.
- Async reset mid-stream:
  - with count=7, pull rst low between clock edges.
  - Required: read_ready=0, write_ready=0, out_data=0 immediately.
  - After release, push 0x5, pop; out_data=0x5.

Source files
------------

// File: rtl/hls_stream_fifo.sv
// Single-clock stream FIFO that feeds generated read kernels; valid/ready handshake on both the write and read sides.
// Latency: a pushed word can be popped from the next cycle; a popped word appears on out_data the cycle after the pop and holds until the next pop.
// Backpressure: write_ready drops at full and read_ready drops at empty, both from registered state only; a request that is not ready is dropped silently.
module hls_stream_fifo #(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 16,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sclr,
   input  logic [WIDTH-1:0] in_data,
   input  logic             write_valid,
   output logic             write_ready,
   input  logic             read_valid,
   output logic             read_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;

   // Occupancy flags come only from the count register, so there is no path from the request inputs to the ready outputs.
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

   // The async-reset flops already dominate during reset, so push and pop need no reset term.
   // Only the visible ready outputs are forced low while reset is held.
   assign push        = write_valid & ~full;
   assign pop         = read_valid & ~empty;
   assign write_ready = rst & ~full;
   assign read_ready  = rst & ~empty;

   // Storage write. The array is deliberately not reset, and a clear discards a push issued in the same cycle.
   always_ff @(posedge clk) begin
      if (push && !sclr) begin
         mem[wr_ptr] <= in_data;
      end
   end

   // Pointers and occupancy. A clear has priority over a push or pop in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (sclr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Registered read data. It updates only on a pop, so a clear leaves the last popped word in place.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_data <= '0;
      end else if (pop && !sclr) begin
         out_data <= mem[rd_ptr];
      end
   end

endmodule

// File: tb/tb_hls_stream_fifo.sv
// Testbench for hls_stream_fifo: table vectors, hand-written corner sequences and random traffic.
// Every cycle is compared against a queue-based reference model of the FIFO.
// Inputs are driven 1 time unit after the rising edge, and outputs are sampled at the same point.
module tb_hls_stream_fifo;

   localparam int WIDTH = 32;
   localparam int DEPTH = 16;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic             clk;
   logic             rst;
   logic             sclr;
   logic [WIDTH-1:0] in_data;
   logic             write_valid;
   logic             write_ready;
   logic             read_valid;
   logic             read_ready;
   logic [WIDTH-1:0] out_data;
   logic [CNT_W-1:0] count;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: a plain queue holding the contents, plus the last popped word.
   logic [WIDTH-1:0] mq[$];
   logic [WIDTH-1:0] m_out;

   typedef struct {
      logic        wv;
      logic [31:0] din;
      logic        rv;
      logic        sc;
      logic [4:0]  exp_count;
      logic        exp_rr;
      logic        exp_wr;
      logic [31:0] exp_out;
   } vec_t;

   vec_t tbl[14];

   hls_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .sclr        (sclr),
      .in_data     (in_data),
      .write_valid (write_valid),
      .write_ready (write_ready),
      .read_valid  (read_valid),
      .read_ready  (read_ready),
      .out_data    (out_data),
      .count       (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_out = '0;
   endtask

   // Drive one cycle of inputs, advance the model by the FIFO rules, then compare the DUT with the model after the edge.
   task automatic cycle(input logic wv, input logic [31:0] din, input logic rv, input logic sc);
      bit wr_ok;
      bit rd_ok;
      write_valid = wv;
      in_data     = din;
      read_valid  = rv;
      sclr        = sc;
      wr_ok = (mq.size() != DEPTH);
      rd_ok = (mq.size() != 0);
      if (sc) begin
         mq.delete();
      end else begin
         if (rv && rd_ok) m_out = mq.pop_front();
         if (wv && wr_ok) mq.push_back(din);
      end
      @(posedge clk);
      #1;
      check("m_count", 32'(count), 32'(mq.size()));
      check("m_read_ready", 32'(read_ready), 32'(mq.size() != 0));
      check("m_write_ready", 32'(write_ready), 32'(mq.size() != DEPTH));
      check("m_out_data", out_data, m_out);
      write_valid = 1'b0;
      read_valid  = 1'b0;
      sclr        = 1'b0;
   endtask

   // Watchdog: the run must never hang.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] held;

      // Reset then idle, kernel-style single read, an empty push+pop with no bypass, and a simultaneous push/pop.
      tbl[0]  = '{1'b0, 32'h0,        1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0};
      tbl[1]  = '{1'b0, 32'h0,        1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0};
      tbl[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 32'h0};
      tbl[3]  = '{1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 32'h0};
      tbl[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 32'hDEADBEEF};
      for (int i = 5; i < 10; i++)
         tbl[i] = '{1'b0, 32'h0,      1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'hDEADBEEF};
      tbl[10] = '{1'b1, 32'hA1,       1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 32'hDEADBEEF};
      tbl[11] = '{1'b1, 32'hA2,       1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 32'hA1};
      tbl[12] = '{1'b0, 32'h0,        1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 32'hA2};
      tbl[13] = '{1'b0, 32'h0,        1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 32'hA2};

      rst = 1'b0; sclr = 1'b0; in_data = '0; write_valid = 1'b0; read_valid = 1'b0;
      model_reset();
      #12;
      check("rst_count", 32'(count), 32'd0);
      check("rst_read_ready", 32'(read_ready), 32'd0);
      check("rst_write_ready", 32'(write_ready), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("post_rst_write_ready", 32'(write_ready), 32'd1);
      @(posedge clk);
      #1;

      for (int i = 0; i < 14; i++) begin
         cycle(tbl[i].wv, tbl[i].din, tbl[i].rv, tbl[i].sc);
         check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].exp_count));
         check($sformatf("tbl%0d_read_ready", i), 32'(read_ready), 32'(tbl[i].exp_rr));
         check($sformatf("tbl%0d_write_ready", i), 32'(write_ready), 32'(tbl[i].exp_wr));
         check($sformatf("tbl%0d_out_data", i), out_data, tbl[i].exp_out);
      end

      // Fill to full, push into a full FIFO, then drain in order.
      for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 32'(i), 1'b0, 1'b0);
      check("full_count", 32'(count), 32'd16);
      check("full_write_ready", 32'(write_ready), 32'd0);
      cycle(1'b1, 32'd99, 1'b0, 1'b0);
      check("full_ignore_count", 32'(count), 32'd16);
      for (int i = 1; i <= DEPTH; i++) begin
         cycle(1'b0, 32'h0, 1'b1, 1'b0);
         check($sformatf("drain%0d_out", i), out_data, 32'(i));
         if (i == 1) check("after_first_pop_write_ready", 32'(write_ready), 32'd1);
      end

      // Wrap with simultaneous push and pop at a steady occupancy of 10.
      for (int k = 0; k < 10; k++) cycle(1'b1, 32'h100 + 32'(k), 1'b0, 1'b0);
      for (int k = 0; k < 30; k++) begin
         cycle(1'b1, 32'h200 + 32'(k), 1'b1, 1'b0);
         check($sformatf("wrap%0d_count", k), 32'(count), 32'd10);
      end

      // A clear has priority over a same-cycle push and pop, and out_data is held.
      for (int k = 0; k < 5; k++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
      check("pre_sclr_count", 32'(count), 32'd5);
      held = out_data;
      cycle(1'b1, 32'h777, 1'b1, 1'b1);
      check("sclr_count", 32'(count), 32'd0);
      check("sclr_read_ready", 32'(read_ready), 32'd0);
      check("sclr_out_held", out_data, held);

      // Asynchronous reset asserted between clock edges while the FIFO holds data.
      for (int k = 0; k < 7; k++) cycle(1'b1, 32'h300 + 32'(k), 1'b0, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      check("arst_read_ready", 32'(read_ready), 32'd0);
      check("arst_write_ready", 32'(write_ready), 32'd0);
      check("arst_out_data", out_data, 32'd0);
      check("arst_count", 32'(count), 32'd0);
      model_reset();
      #2;
      rst = 1'b1;
      @(posedge clk);
      #1;
      cycle(1'b1, 32'h5, 1'b0, 1'b0);
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
      check("arst_first_word", out_data, 32'h5);

      // Random traffic against the model, with occasional clears.
      for (int n = 0; n < 2000; n++) begin
         cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 63) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
